uart_stream_bridge: RTL and testbench

Buffered, parametrised byte bridge between the UART core and a stream consumer/producer such as the DAU plus its symbol converters. It replaces the single-FIFO glue in the calculator top level with independent RX and TX FIFOs. It honours consumer backpressure and has optional local echo of received bytes. Overflow reporting is sticky, and a saturating drop counter records lost bytes.

---
 rtl/uart_stream_bridge_pkg.sv | 18 +
 rtl/uart_stream_bridge_sync_fifo.sv | 89 ++++++++
 rtl/uart_stream_bridge.sv | 149 ++++++++++++++
 tb/tb_uart_stream_bridge.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_stream_bridge_pkg.sv
// Shared defaults and types for the UART stream bridge and its FIFOs.
package uart_stream_bridge_pkg;

    // Default geometry reused by the top level and the FIFO sub-module.
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_RX_DEPTH   = 16;
    localparam int DEF_TX_DEPTH   = 26;
    localparam int DEF_CNT_WIDTH  = 8;

    // FIFO operation for one cycle, encoded as {read, write}.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/uart_stream_bridge_sync_fifo.sv
// Synchronous FIFO with arbitrary depth. Pointers wrap by comparison, and
// full/empty come from an occupancy register, so any DEPTH >= 2 works.
// A write while full is accepted when a read is accepted in the same cycle.
module sync_fifo
    import uart_stream_bridge_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  DEPTH      = DEF_RX_DEPTH,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW         = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr,
    input  logic                  i_rd,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [LW-1:0]         o_level
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [LW-1:0]         level_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_en_s;
    logic                  rd_en_s;
    fifo_op_e              op_s;

    // Advance a pointer, wrapping from DEPTH-1 back to zero.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        logic [AW-1:0] nxt;
        if (ptr == AW'(DEPTH - 1)) begin
            nxt = {AW{1'b0}};
        end else begin
            nxt = ptr + AW'(1);
        end
        return nxt;
    endfunction

    assign full_s  = (level_r == LW'(DEPTH));
    assign empty_s = (level_r == {LW{1'b0}});
    assign rd_en_s = i_rd & ~empty_s;
    assign wr_en_s = i_wr & (~full_s | rd_en_s);
    assign op_s    = fifo_op_e'({rd_en_s, wr_en_s});

    assign o_rd_data = mem_r[rd_ptr_r];
    assign o_full    = full_s;
    assign o_empty   = empty_s;
    assign o_level   = level_r;

    // Pointer and occupancy bookkeeping; simultaneous push and pop keeps the level.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            case (op_s)
                FIFO_PUSH: begin
                    wr_ptr_r <= next_ptr(wr_ptr_r);
                    level_r  <= level_r + LW'(1);
                end
                FIFO_POP: begin
                    rd_ptr_r <= next_ptr(rd_ptr_r);
                    level_r  <= level_r - LW'(1);
                end
                FIFO_BOTH: begin
                    wr_ptr_r <= next_ptr(wr_ptr_r);
                    rd_ptr_r <= next_ptr(rd_ptr_r);
                end
                default: begin
                    level_r <= level_r;
                end
            endcase
        end
    end

    // Storage write; blocked while reset is held so a discarded byte never lands.
    always_ff @(posedge i_clk) begin
        if (i_rst && wr_en_s) begin
            mem_r[wr_ptr_r] <= i_wr_data;
        end
    end

endmodule

// File: rtl/uart_stream_bridge.sv
// Buffered bridge between a UART core and a byte stream consumer/producer.
// RX bytes queue toward the consumer, producer bytes queue toward the UART,
// with optional local echo, sticky loss flags and a saturating drop counter.
module uart_stream_bridge
    import uart_stream_bridge_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  RX_DEPTH   = DEF_RX_DEPTH,
    parameter int  TX_DEPTH   = DEF_TX_DEPTH,
    parameter int  ECHO       = 0,
    parameter int  CNT_WIDTH  = DEF_CNT_WIDTH,
    localparam int RX_LW      = $clog2(RX_DEPTH + 1),
    localparam int TX_LW      = $clog2(TX_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    output logic                  o_tx_start,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    input  logic                  i_tx_done,
    output logic                  o_m_valid,
    output logic [DATA_WIDTH-1:0] o_m_data,
    input  logic                  i_m_ready,
    input  logic                  i_s_valid,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    output logic                  o_s_ready,
    input  logic                  i_clr,
    output logic                  o_rx_overflow,
    output logic                  o_echo_lost,
    output logic [CNT_WIDTH-1:0]  o_drop_cnt,
    output logic [RX_LW-1:0]      o_rx_level,
    output logic [TX_LW-1:0]      o_tx_level
);

    localparam logic ECHO_EN = (ECHO != 0);

    logic                  rx_full_s;
    logic                  rx_empty_s;
    logic                  rx_pop_s;
    logic                  rx_drop_s;
    logic                  tx_full_s;
    logic                  tx_empty_s;
    logic                  tx_pop_s;
    logic                  tx_room_s;
    logic                  echo_wr_s;
    logic                  echo_lost_s;
    logic                  s_ready_s;
    logic                  tx_wr_s;
    logic [DATA_WIDTH-1:0] tx_wr_data_s;
    logic                  rx_overflow_r;
    logic                  echo_lost_r;
    logic [CNT_WIDTH-1:0]  drop_cnt_r;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val);
        logic [CNT_WIDTH-1:0] res;
        if (val == {CNT_WIDTH{1'b1}}) begin
            res = val;
        end else begin
            res = val + CNT_WIDTH'(1);
        end
        return res;
    endfunction

    // RX side: a byte is lost only when the FIFO is full and nothing leaves this cycle.
    assign rx_pop_s  = i_m_ready & ~rx_empty_s;
    assign rx_drop_s = i_rx_done & rx_full_s & ~rx_pop_s;

    // TX side: a pop this cycle frees a slot for a write in the same cycle.
    assign tx_pop_s    = i_tx_done & ~tx_empty_s;
    assign tx_room_s   = ~tx_full_s | tx_pop_s;
    assign echo_wr_s   = ECHO_EN & i_rx_done;
    assign echo_lost_s = echo_wr_s & ~tx_room_s;
    assign s_ready_s   = tx_room_s & ~echo_wr_s;

    // Arbitrate the single TX write port: echo first, producer otherwise.
    always_comb begin
        tx_wr_s      = 1'b0;
        tx_wr_data_s = i_s_data;
        if (echo_wr_s) begin
            tx_wr_s      = tx_room_s;
            tx_wr_data_s = i_rx_data;
        end else begin
            tx_wr_s      = i_s_valid & s_ready_s;
            tx_wr_data_s = i_s_data;
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RX_DEPTH)
    ) u_rx_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr       (i_rx_done),
        .i_rd       (i_m_ready),
        .i_wr_data  (i_rx_data),
        .o_rd_data  (o_m_data),
        .o_full     (rx_full_s),
        .o_empty    (rx_empty_s),
        .o_level    (o_rx_level)
    );

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (TX_DEPTH)
    ) u_tx_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr       (tx_wr_s),
        .i_rd       (i_tx_done),
        .i_wr_data  (tx_wr_data_s),
        .o_rd_data  (o_tx_data),
        .o_full     (tx_full_s),
        .o_empty    (tx_empty_s),
        .o_level    (o_tx_level)
    );

    // Sticky loss flags and drop counter; a drop in the same cycle as a clear wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rx_overflow_r <= 1'b0;
            echo_lost_r   <= 1'b0;
            drop_cnt_r    <= {CNT_WIDTH{1'b0}};
        end else begin
            if (rx_drop_s) begin
                rx_overflow_r <= 1'b1;
                drop_cnt_r    <= i_clr ? CNT_WIDTH'(1) : sat_inc(drop_cnt_r);
            end else if (i_clr) begin
                rx_overflow_r <= 1'b0;
                drop_cnt_r    <= {CNT_WIDTH{1'b0}};
            end
            if (echo_lost_s) begin
                echo_lost_r <= 1'b1;
            end else if (i_clr) begin
                echo_lost_r <= 1'b0;
            end
        end
    end

    assign o_m_valid     = ~rx_empty_s;
    assign o_tx_start    = ~tx_empty_s;
    assign o_s_ready     = s_ready_s;
    assign o_rx_overflow = rx_overflow_r;
    assign o_echo_lost   = echo_lost_r;
    assign o_drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Scoreboard bench for uart_stream_bridge with small depths and echo enabled.
module tb_uart_stream_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready;
    logic       clr = 1'b0;
    logic       rx_overflow;
    logic       echo_lost;
    logic [7:0] drop_cnt;
    logic [2:0] rx_level;
    logic [2:0] tx_level;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rx_e;
    logic [7:0] tx_e;

    uart_stream_bridge #(
        .DATA_WIDTH (8),
        .RX_DEPTH   (4),
        .TX_DEPTH   (5),
        .ECHO       (1),
        .CNT_WIDTH  (8)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rx_done     (rx_done),
        .i_rx_data     (rx_data),
        .o_tx_start    (tx_start),
        .o_tx_data     (tx_data),
        .i_tx_done     (tx_done),
        .o_m_valid     (m_valid),
        .o_m_data      (m_data),
        .i_m_ready     (m_ready),
        .i_s_valid     (s_valid),
        .i_s_data      (s_data),
        .o_s_ready     (s_ready),
        .i_clr         (clr),
        .o_rx_overflow (rx_overflow),
        .o_echo_lost   (echo_lost),
        .o_drop_cnt    (drop_cnt),
        .o_rx_level    (rx_level),
        .o_tx_level    (tx_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted RX or TX head is compared with the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (m_valid && m_ready) begin
                if (rx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got 0x%0h, expected no byte", m_data);
                end else begin
                    rx_e = rx_q.pop_front();
                    check("rx_data", 32'(m_data), 32'(rx_e));
                end
            end
            if (tx_start && tx_done) begin
                if (tx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got 0x%0h, expected no byte", tx_data);
                end else begin
                    tx_e = tx_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(tx_e));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick;
        tick;
        rst = 1'b1;
        // Reset state
        check("rst_rx_level", 32'(rx_level), 32'd0);
        check("rst_tx_level", 32'(tx_level), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_overflow", 32'(rx_overflow), 32'd0);
        check("rst_echo_lost", 32'(echo_lost), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);

        // Reset mid-operation: 3 bytes in RX and 3 echoes in TX are discarded
        for (int i = 0; i < 3; i++) begin
            rx_done = 1'b1;
            rx_data = 8'hA1 + 8'(i);
            tick;
        end
        rx_done = 1'b0;
        check("load_rx_level", 32'(rx_level), 32'd3);
        check("load_tx_level", 32'(tx_level), 32'd3);
        rst = 1'b0;
        tick;
        rst = 1'b1;
        check("mid_rst_rx_level", 32'(rx_level), 32'd0);
        check("mid_rst_tx_level", 32'(tx_level), 32'd0);
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_tx_start", 32'(tx_start), 32'd0);
        check("mid_rst_s_ready", 32'(s_ready), 32'd1);

        // RX ordering with consumer stalled, echoes fill TX
        rx_done = 1'b1;
        rx_data = 8'h31;
        rx_q.push_back(8'h31);
        tx_q.push_back(8'h31);
        tick;
        check("rx_valid_latency", 32'(m_valid), 32'd1);
        check("echo_start_latency", 32'(tx_start), 32'd1);
        rx_data = 8'h32;
        rx_q.push_back(8'h32);
        tx_q.push_back(8'h32);
        tick;
        rx_data = 8'h2B;
        rx_q.push_back(8'h2B);
        tx_q.push_back(8'h2B);
        tick;
        rx_done = 1'b0;
        check("order_rx_level", 32'(rx_level), 32'd3);
        check("order_tx_level", 32'(tx_level), 32'd3);
        m_ready = 1'b1;
        tx_done = 1'b1;
        repeat (3) tick;
        m_ready = 1'b0;
        tx_done = 1'b0;
        check("order_rx_drained", 32'(rx_level), 32'd0);
        check("order_m_valid_low", 32'(m_valid), 32'd0);
        check("order_tx_drained", 32'(tx_level), 32'd0);

        // RX overflow: 6 bytes into a 4-deep FIFO, TX kept draining
        tx_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rx_done = 1'b1;
            rx_data = 8'h50 + 8'(i);
            tx_q.push_back(8'h50 + 8'(i));
            if (i < 4) rx_q.push_back(8'h50 + 8'(i));
            tick;
        end
        rx_done = 1'b0;
        tick;
        check("ovf_rx_level", 32'(rx_level), 32'd4);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
        check("ovf_flag", 32'(rx_overflow), 32'd1);
        check("ovf_echo_lost", 32'(echo_lost), 32'd0);
        check("ovf_tx_level", 32'(tx_level), 32'd0);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
        check("clr_flag", 32'(rx_overflow), 32'd0);
        // Clear coinciding with a drop: the drop wins
        clr = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'h5F;
        tx_q.push_back(8'h5F);
        tick;
        clr = 1'b0;
        rx_done = 1'b0;
        tick;
        check("clr_drop_cnt_wins", 32'(drop_cnt), 32'd1);
        check("clr_drop_flag_wins", 32'(rx_overflow), 32'd1);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        check("clr2_drop_cnt", 32'(drop_cnt), 32'd0);
        tx_done = 1'b0;
        m_ready = 1'b1;
        repeat (4) tick;
        m_ready = 1'b0;
        check("ovf_rx_drained", 32'(rx_level), 32'd0);

        // TX handshake
        s_valid = 1'b1;
        s_data = 8'h35;
        #1;
        check("hs_s_ready", 32'(s_ready), 32'd1);
        tx_q.push_back(8'h35);
        tick;
        check("hs_start_latency", 32'(tx_start), 32'd1);
        s_data = 8'h0D;
        tx_q.push_back(8'h0D);
        tick;
        s_valid = 1'b0;
        check("hs_tx_level", 32'(tx_level), 32'd2);
        check("hs_head_first", 32'(tx_data), 32'h35);
        tick;
        check("hs_head_hold", 32'(tx_data), 32'h35);
        tx_done = 1'b1;
        tick;
        check("hs_head_second", 32'(tx_data), 32'h0D);
        tick;
        check("hs_start_falls", 32'(tx_start), 32'd0);
        tick;
        tx_done = 1'b0;
        check("hs_done_when_empty", 32'(tx_level), 32'd0);

        // Echo priority over the producer
        rx_done = 1'b1;
        rx_data = 8'h37;
        s_valid = 1'b1;
        s_data = 8'h41;
        #1;
        check("echo_s_ready_low", 32'(s_ready), 32'd0);
        rx_q.push_back(8'h37);
        tx_q.push_back(8'h37);
        tick;
        rx_done = 1'b0;
        #1;
        check("echo_s_ready_back", 32'(s_ready), 32'd1);
        tx_q.push_back(8'h41);
        tick;
        check("echo_tx_level", 32'(tx_level), 32'd2);
        check("echo_tx_head", 32'(tx_data), 32'h37);
        check("echo_m_data", 32'(m_data), 32'h37);
        for (int i = 0; i < 3; i++) begin
            s_data = 8'h61 + 8'(i);
            tx_q.push_back(8'h61 + 8'(i));
            tick;
        end
        s_data = 8'h64;
        #1;
        check("full_s_ready", 32'(s_ready), 32'd0);
        tick;
        s_valid = 1'b0;
        check("full_tx_level", 32'(tx_level), 32'd5);
        // Echo against a full TX FIFO is lost, RX copy still lands
        rx_done = 1'b1;
        rx_data = 8'h37;
        rx_q.push_back(8'h37);
        tick;
        rx_done = 1'b0;
        check("lost_flag", 32'(echo_lost), 32'd1);
        check("lost_rx_level", 32'(rx_level), 32'd2);
        check("lost_rx_overflow", 32'(rx_overflow), 32'd0);
        check("lost_tx_level", 32'(tx_level), 32'd5);
        m_ready = 1'b1;
        repeat (2) tick;
        m_ready = 1'b0;

        // Wrap: push+pop while full, then 12 interleaved push/pop
        s_valid = 1'b1;
        s_data = 8'h70;
        tx_done = 1'b1;
        #1;
        check("wrap_s_ready_full_pop", 32'(s_ready), 32'd1);
        tx_q.push_back(8'h70);
        tick;
        check("wrap_level_full", 32'(tx_level), 32'd5);
        for (int i = 0; i < 12; i++) begin
            s_data = 8'h80 + 8'(i);
            tx_q.push_back(8'h80 + 8'(i));
            tick;
        end
        s_valid = 1'b0;
        check("wrap_level_kept", 32'(tx_level), 32'd5);
        repeat (5) tick;
        tx_done = 1'b0;
        check("wrap_drained", 32'(tx_level), 32'd0);
        check("wrap_start_low", 32'(tx_start), 32'd0);

        clr = 1'b1;
        tick;
        clr = 1'b0;
        check("clr_echo_lost", 32'(echo_lost), 32'd0);
        check("rx_scoreboard_empty", 32'(rx_q.size()), 32'd0);
        check("tx_scoreboard_empty", 32'(tx_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
